tt_logic_engine: RTL

Programmable, pipelined truth-table logic engine: evaluates N_OUT independent Boolean functions of N_IN inputs, each defined by a 2^N_IN-bit truth table. It generalises our fixed 4-input gate-netlist circuits (e.g. 0xDA80) into a runtime-reconfigurable block. It sits between a stimulus source and a result sink using valid/ready handshakes. Truth tables reload over a serial configuration port without reset.

---
 rtl/tt_logic_engine_if.sv | 32 +++
 rtl/tt_logic_engine.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tt_logic_engine_if.sv
// tt_logic_engine_if: handshake and configuration bundle for tt_logic_engine.
//   Config    : cfg_start, cfg_valid, cfg_bit (to engine); cfg_busy, cfg_done (from engine)
//   Input     : in_valid, in_data[N_IN] (to engine); in_ready (from engine)
//   Output    : out_valid, out_data[N_OUT], eval_count[16] (from engine); out_ready (to engine)
// The slave modport is the engine side; the master modport is the driver/sink side.
interface tt_logic_engine_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 1
);
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_bit;
    logic              cfg_busy;
    logic              cfg_done;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic [15:0]       eval_count;

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
        output cfg_busy, cfg_done, in_ready, out_valid, out_data, eval_count
    );

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_data, out_ready,
        input  cfg_busy, cfg_done, in_ready, out_valid, out_data, eval_count
    );
endinterface

// File: rtl/tt_logic_engine.sv
// tt_logic_engine: pipelined, runtime-reconfigurable truth-table logic engine.
// Evaluates N_OUT Boolean functions of an N_IN-bit input vector; channel c's table
// lives in bits [c*TT_W +: TT_W] of the active table register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tt_logic_engine_if.slave (config serial port, input and output handshakes)
// Pipeline: S1 captures the index, the output stage holds the looked-up result.
// A serial load fills a shadow table; the commit swaps it in once S1 is empty so
// every accepted input is evaluated with the table that was live when it arrived.
module tt_logic_engine #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 1,
    localparam int unsigned TT_W    = 1 << N_IN,
    localparam int unsigned TT_BITS = N_OUT * TT_W,
    parameter logic [TT_BITS-1:0] TT_RESET = TT_BITS'({N_OUT{16'hDA80}})
) (
    input logic              clk,
    input logic              rst_n,
    tt_logic_engine_if.slave bus
);

    localparam int unsigned CNT_W = (TT_BITS > 1) ? $clog2(TT_BITS) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StCommit = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TT_BITS-1:0] r_shadow;
    logic [TT_BITS-1:0] r_active;
    logic               r_done;

    logic               r_s1_valid;
    logic [N_IN-1:0]    r_s1_idx;
    logic               r_out_valid;
    logic [N_OUT-1:0]   r_out_data;
    logic [15:0]        r_eval;

    logic               w_en;
    logic               w_in_ready;
    logic [N_OUT-1:0]   w_lookup;

    // Whole pipeline advances together; a stalled output stage freezes S1 too.
    assign w_en       = !r_out_valid || bus.out_ready;
    // rst_n term keeps in_ready low while reset is held, not just after it.
    assign w_in_ready = rst_n && w_en && (r_state == StIdle) && !bus.cfg_start;

    always_comb begin
        w_lookup = '0;
        for (int c = 0; c < int'(N_OUT); c++) begin
            w_lookup[c] = r_active[c * int'(TT_W) + int'(r_s1_idx)];
        end
    end

    // Configuration FSM and table storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= TT_RESET;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.cfg_start) begin
                        r_state <= StLoad;
                        r_cnt   <= '0;
                    end
                end
                StLoad: begin
                    // Restart takes priority over a beat presented in the same cycle.
                    if (bus.cfg_start) begin
                        r_cnt <= '0;
                    end else if (bus.cfg_valid) begin
                        r_shadow[r_cnt] <= bus.cfg_bit;
                        if (r_cnt == CNT_W'(TT_BITS - 1)) begin
                            r_state <= StCommit;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StCommit: begin
                    // Wait for S1 to drain so in-flight inputs use the old tables.
                    if (!r_s1_valid) begin
                        r_active <= r_shadow;
                        r_state  <= StIdle;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Two-stage evaluation pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid && w_in_ready;
            r_s1_idx    <= bus.in_data;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_lookup;
            end
        end
    end

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eval <= '0;
        end else if (r_out_valid && bus.out_ready && (r_eval != 16'hFFFF)) begin
            r_eval <= r_eval + 16'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.eval_count = r_eval;
    assign bus.cfg_busy   = (r_state != StIdle);
    assign bus.cfg_done   = r_done;

endmodule
